// File: rtl/store_queue_gen.sv
// Two-stage store queue: speculative FIFO feeding a commit FIFO
// that drains to the D$, with optional doubleword write-combining.
module store_queue_gen #(
  parameter int unsigned DEPTH_SPEC   = 4,
  parameter int unsigned DEPTH_COMMIT = 8,
  parameter bit          MERGE_EN     = 1'b1,
  localparam int SCW = $clog2(DEPTH_SPEC + 1),
  localparam int CCW = $clog2(DEPTH_COMMIT + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           flush_i,
  input  logic           valid_i,
  output logic           ready_o,
  input  logic [63:0]    paddr_i,
  input  logic [63:0]    data_i,
  input  logic [7:0]     be_i,
  input  logic [1:0]     data_size_i,
  input  logic           commit_i,
  output logic           commit_ready_o,
  input  logic [11:0]    page_offset_i,
  output logic           page_offset_matches_o,
  output logic           no_st_pending_o,
  output logic           req_o,
  input  logic           gnt_i,
  output logic [63:0]    addr_o,
  output logic [63:0]    wdata_o,
  output logic [7:0]     be_o,
  output logic [1:0]     size_o,
  output logic [SCW-1:0] spec_cnt_o,
  output logic [CCW-1:0] commit_cnt_o
);

  localparam int SPW = $clog2(DEPTH_SPEC);
  localparam int CPW = $clog2(DEPTH_COMMIT);

  logic [63:0]    s_addr_q [DEPTH_SPEC];
  logic [63:0]    s_data_q [DEPTH_SPEC];
  logic [7:0]     s_be_q   [DEPTH_SPEC];
  logic [1:0]     s_size_q [DEPTH_SPEC];
  logic [SPW-1:0] s_rptr_q, s_rptr_d;
  logic [SPW-1:0] s_wptr_q, s_wptr_d;
  logic [SCW-1:0] s_cnt_q, s_cnt_d;

  logic [63:0]    c_addr_q [DEPTH_COMMIT];
  logic [63:0]    c_data_q [DEPTH_COMMIT];
  logic [7:0]     c_be_q   [DEPTH_COMMIT];
  logic [1:0]     c_size_q [DEPTH_COMMIT];
  logic [CPW-1:0] c_rptr_q, c_rptr_d;
  logic [CPW-1:0] c_wptr_q, c_wptr_d;
  logic [CCW-1:0] c_cnt_q, c_cnt_d;

  logic           s_push, s_pop;
  logic           c_push, c_pop;
  logic           merge;
  logic [CPW-1:0] c_tail;

  logic           unused_po;
  assign unused_po = ^page_offset_i[2:0];

  assign ready_o         = s_cnt_q < SCW'(DEPTH_SPEC);
  assign commit_ready_o  = c_cnt_q < CCW'(DEPTH_COMMIT);
  assign req_o           = c_cnt_q != '0;
  assign no_st_pending_o = (s_cnt_q == '0) && (c_cnt_q == '0);
  assign spec_cnt_o      = s_cnt_q;
  assign commit_cnt_o    = c_cnt_q;

  assign addr_o  = req_o ? c_addr_q[c_rptr_q] : '0;
  assign wdata_o = req_o ? c_data_q[c_rptr_q] : '0;
  assign be_o    = req_o ? c_be_q[c_rptr_q]   : '0;
  assign size_o  = req_o ? c_size_q[c_rptr_q] : '0;

  // Handshake decode and next-state pointers/counts for both FIFOs.
  always_comb begin
    s_push = valid_i && ready_o && !flush_i;
    s_pop  = commit_i && (s_cnt_q != '0);
    c_tail = c_wptr_q - CPW'(1);
    merge  = MERGE_EN && s_pop
          && (c_cnt_q >= CCW'(2))
          && (c_addr_q[c_tail][63:3]
              == s_addr_q[s_rptr_q][63:3]);
    c_push = s_pop && !merge;
    c_pop  = req_o && gnt_i;

    s_rptr_d = s_rptr_q + SPW'(s_pop);
    s_wptr_d = s_wptr_q + SPW'(s_push);
    s_cnt_d  = s_cnt_q + SCW'(s_push)
             - SCW'(s_pop);
    if (flush_i) begin
      s_rptr_d = '0;
      s_wptr_d = '0;
      s_cnt_d  = '0;
    end

    c_rptr_d = c_rptr_q + CPW'(c_pop);
    c_wptr_d = c_wptr_q + CPW'(c_push);
    c_cnt_d  = c_cnt_q + CCW'(c_push)
             - CCW'(c_pop);
  end

  // Load hazard: any live store in either FIFO, or the incoming one.
  always_comb begin
    logic [SPW-1:0] soff;
    logic [CPW-1:0] coff;
    page_offset_matches_o = valid_i
      && (paddr_i[11:3] == page_offset_i[11:3]);
    for (int i = 0; i < int'(DEPTH_SPEC); i++) begin
      soff = SPW'(i) - s_rptr_q;
      if (({1'b0, soff} < s_cnt_q)
          && (s_addr_q[i][11:3] == page_offset_i[11:3]))
        page_offset_matches_o = 1'b1;
    end
    for (int i = 0; i < int'(DEPTH_COMMIT); i++) begin
      coff = CPW'(i) - c_rptr_q;
      if (({1'b0, coff} < c_cnt_q)
          && (c_addr_q[i][11:3] == page_offset_i[11:3]))
        page_offset_matches_o = 1'b1;
    end
  end

  // Speculative FIFO storage and pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH_SPEC); i++) begin
        s_addr_q[i] <= '0;
        s_data_q[i] <= '0;
        s_be_q[i]   <= '0;
        s_size_q[i] <= '0;
      end
      s_rptr_q <= '0;
      s_wptr_q <= '0;
      s_cnt_q  <= '0;
    end else begin
      if (s_push) begin
        s_addr_q[s_wptr_q] <= paddr_i;
        s_data_q[s_wptr_q] <= data_i;
        s_be_q[s_wptr_q]   <= be_i;
        s_size_q[s_wptr_q] <= data_size_i;
      end
      s_rptr_q <= s_rptr_d;
      s_wptr_q <= s_wptr_d;
      s_cnt_q  <= s_cnt_d;
    end
  end

  // Commit FIFO: allocate or combine into the tail, drain from head.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH_COMMIT); i++) begin
        c_addr_q[i] <= '0;
        c_data_q[i] <= '0;
        c_be_q[i]   <= '0;
        c_size_q[i] <= '0;
      end
      c_rptr_q <= '0;
      c_wptr_q <= '0;
      c_cnt_q  <= '0;
    end else begin
      if (c_push) begin
        c_addr_q[c_wptr_q] <= s_addr_q[s_rptr_q];
        c_data_q[c_wptr_q] <= s_data_q[s_rptr_q];
        c_be_q[c_wptr_q]   <= s_be_q[s_rptr_q];
        c_size_q[c_wptr_q] <= s_size_q[s_rptr_q];
      end
      if (merge) begin
        for (int b = 0; b < 8; b++)
          if (s_be_q[s_rptr_q][b])
            c_data_q[c_tail][8*b +: 8]
              <= s_data_q[s_rptr_q][8*b +: 8];
        c_be_q[c_tail]   <= c_be_q[c_tail]
                          | s_be_q[s_rptr_q];
        c_size_q[c_tail] <= 2'd3;
      end
      c_rptr_q <= c_rptr_d;
      c_wptr_q <= c_wptr_d;
      c_cnt_q  <= c_cnt_d;
    end
  end

  a_commit_nonempty: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    commit_i |-> (s_cnt_q != '0));

  a_commit_room: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    c_push |-> (commit_ready_o || c_pop));

endmodule

// File: tb/tb_store_queue_gen.sv
// Directed and random checks of store_queue_gen against a
// queue-based reference model of the two store FIFOs.
module tb_store_queue_gen;

  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
    logic [7:0]  be;
    logic [1:0]  sz;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush_i = 0, valid_i = 0, commit_i = 0, gnt_i = 0;
  logic [63:0] paddr_i = '0, data_i = '0;
  logic [7:0]  be_i = '0;
  logic [1:0]  data_size_i = '0;
  logic [11:0] page_offset_i = '0;
  logic        ready_o, commit_ready_o, page_offset_matches_o;
  logic        no_st_pending_o, req_o;
  logic [63:0] addr_o, wdata_o;
  logic [7:0]  be_o;
  logic [1:0]  size_o;
  logic [2:0]  spec_cnt_o;
  logic [3:0]  commit_cnt_o;

  int n_chk = 0;
  int n_fail = 0;
  ent_t sq[$];
  ent_t cq[$];

  always #5 clk = ~clk;

  store_queue_gen dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .paddr_i(paddr_i), .data_i(data_i), .be_i(be_i),
    .data_size_i(data_size_i), .commit_i(commit_i),
    .commit_ready_o(commit_ready_o),
    .page_offset_i(page_offset_i),
    .page_offset_matches_o(page_offset_matches_o),
    .no_st_pending_o(no_st_pending_o), .req_o(req_o),
    .gnt_i(gnt_i), .addr_o(addr_o), .wdata_o(wdata_o),
    .be_o(be_o), .size_o(size_o),
    .spec_cnt_o(spec_cnt_o), .commit_cnt_o(commit_cnt_o)
  );

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic hz;
    ent_t h;
    h = '{a: 64'h0, d: 64'h0, be: 8'h0, sz: 2'h0};
    if (cq.size() != 0) h = cq[0];
    hz = valid_i && (paddr_i[11:3] == page_offset_i[11:3]);
    foreach (sq[i]) if (sq[i].a[11:3] == page_offset_i[11:3]) hz = 1;
    foreach (cq[i]) if (cq[i].a[11:3] == page_offset_i[11:3]) hz = 1;
    chk("ready", ready_o, 64'(sq.size() < 4));
    chk("commit_ready", commit_ready_o, 64'(cq.size() < 8));
    chk("no_pending", no_st_pending_o,
        64'(sq.size() == 0 && cq.size() == 0));
    chk("req", req_o, 64'(cq.size() != 0));
    chk("spec_cnt", spec_cnt_o, 64'(sq.size()));
    chk("commit_cnt", commit_cnt_o, 64'(cq.size()));
    chk("addr", addr_o, h.a);
    chk("wdata", wdata_o, h.d);
    chk("be", be_o, 64'(h.be));
    chk("size", size_o, 64'(h.sz));
    chk("hazard", page_offset_matches_o, 64'(hz));
  endtask

  task automatic model_step();
    ent_t e, t;
    bit mg, push;
    mg = 0;
    push = valid_i && (sq.size() < 4) && !flush_i;
    if (commit_i) begin
      e = sq.pop_front();
      mg = (cq.size() >= 2)
        && (cq[cq.size()-1].a[63:3] == e.a[63:3]);
    end
    if (gnt_i && cq.size() != 0) void'(cq.pop_front());
    if (commit_i) begin
      if (mg) begin
        t = cq[cq.size()-1];
        for (int b = 0; b < 8; b++)
          if (e.be[b]) t.d[8*b +: 8] = e.d[8*b +: 8];
        t.be = t.be | e.be;
        t.sz = 2'd3;
        cq[cq.size()-1] = t;
      end else cq.push_back(e);
    end
    if (push)
      sq.push_back('{a: paddr_i, d: data_i,
                     be: be_i, sz: data_size_i});
    if (flush_i) sq.delete();
  endtask

  task automatic tick();
    #1;
    check_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_in(logic [63:0] a, logic [63:0] d,
                         logic [7:0] be);
    valid_i = 1; paddr_i = a; data_i = d;
    be_i = be; data_size_i = 2'd2;
  endtask

  task automatic idle();
    valid_i = 0; commit_i = 0; flush_i = 0;
  endtask

  initial begin
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1;

    // 1: fill the speculative FIFO, fifth push must be ignored
    for (int i = 0; i < 4; i++) begin
      push_in(64'h100 * i, 64'(i), 8'h01);
      tick();
    end
    chk("t1_full_ready", ready_o, 0);
    push_in(64'h900, 64'h9, 8'h01);
    tick();
    chk("t1_spec_cnt", spec_cnt_o, 4);
    idle(); gnt_i = 1;
    commit_i = 1;
    repeat (4) tick();
    commit_i = 0;
    repeat (2) tick();
    chk("t1_drained", no_st_pending_o, 1);

    // 2: single store reaches the D$ the cycle after commit
    push_in(64'h1000, 64'h55, 8'h0F);
    tick();
    idle(); commit_i = 1;
    tick();
    commit_i = 0;
    chk("t2_req", req_o, 1);
    chk("t2_addr", addr_o, 64'h1000);
    chk("t2_be", be_o, 8'h0F);
    tick();
    chk("t2_empty", no_st_pending_o, 1);

    // 3: write-combining into the tail behind a stalled head
    gnt_i = 0;
    push_in(64'h2000, 64'h77, 8'hFF); tick();
    push_in(64'h3000, 64'h11223344, 8'h0F); tick();
    push_in(64'h3004, 64'hAABBCCDD_00000000, 8'hF0); tick();
    idle(); commit_i = 1;
    repeat (3) tick();
    commit_i = 0;
    chk("t3_commit_cnt", commit_cnt_o, 2);
    gnt_i = 1;
    tick();
    gnt_i = 0;
    chk("t3_addr", addr_o, 64'h3000);
    chk("t3_be", be_o, 8'hFF);
    chk("t3_size", size_o, 2'd3);
    chk("t3_wdata", wdata_o, 64'hAABBCCDD11223344);
    gnt_i = 1; tick(); gnt_i = 0;

    // 4: flush with a same-cycle commit keeps the committed store
    for (int i = 0; i < 3; i++) begin
      push_in(64'h6000 + 64'(i) * 64'h40, 64'(i), 8'h03);
      tick();
    end
    idle(); flush_i = 1; commit_i = 1;
    tick();
    idle();
    chk("t4_spec_cnt", spec_cnt_o, 0);
    chk("t4_commit_cnt", commit_cnt_o, 1);
    gnt_i = 1; tick(); gnt_i = 0;

    // 5: full commit FIFO, ready stays low in the grant cycle
    for (int i = 0; i < 9; i++) begin
      valid_i = (i < 8);
      paddr_i = 64'h5000 + 64'(i) * 8;
      data_i = 64'(i); be_i = 8'hFF;
      commit_i = (i > 0);
      tick();
    end
    idle();
    chk("t5_full", commit_cnt_o, 8);
    gnt_i = 1;
    #1 chk("t5_same_cycle", commit_ready_o, 0);
    tick();
    gnt_i = 0;
    chk("t5_next_cycle", commit_ready_o, 1);
    gnt_i = 1;
    repeat (8) tick();
    gnt_i = 0;

    // 6: page-offset hazard against a pending store
    push_in(64'h4018, 64'h1, 8'hFF); tick();
    idle();
    page_offset_i = 12'h01C;
    #1 chk("t6_hit", page_offset_matches_o, 1);
    page_offset_i = 12'h020;
    #1 chk("t6_miss", page_offset_matches_o, 0);
    flush_i = 1; tick(); flush_i = 0;

    // random traffic with one asynchronous reset in the middle
    for (int k = 0; k < 400; k++) begin
      if (k == 200) begin
        idle(); gnt_i = 0;
        rst_n = 0;
        sq.delete(); cq.delete();
        #1 check_all();
        @(negedge clk);
        rst_n = 1;
      end
      valid_i = 1'($urandom_range(0, 1));
      paddr_i = 64'h8000_1000 | 64'($urandom_range(0, 31))
              | (64'($urandom_range(0, 1)) << 40);
      data_i = {$urandom, $urandom};
      be_i = 8'($urandom);
      data_size_i = 2'($urandom);
      commit_i = (sq.size() != 0) && (cq.size() < 8)
              && ($urandom_range(0, 1) == 1);
      flush_i = ($urandom_range(0, 15) == 0);
      gnt_i = ($urandom_range(0, 2) != 0);
      page_offset_i = 12'($urandom_range(0, 63));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
